// File: rtl/cmp_share_pkg.sv
// Shared types and helpers for the comparator-sharing arbiter.
// Holds the FSM state encoding and the requester-ID width rule so that
// the arbiter top and the round-robin picker agree on both.
package cmp_share_pkg;

   // Arbiter phases: wait for a request, compare, present the result.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      RESP = 2'd2
   } state_t;

   // Requester ID width: clog2 of the requester count, never below 1 bit
   // so a single-requester build still has a real rsp_id port.
   function automatic int id_width(input int n_req);
      return (n_req > 1) ? $clog2(n_req) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: purely combinational round-robin picker.
// Returns the first asserted req bit found when scanning upward from ptr
// and wrapping around to 0. gnt_onehot, gnt_id and any are all zero when
// no request is asserted. ptr must be below N_REQ.
module rr_pick
   import cmp_share_pkg::*;
#(
   parameter  int N_REQ = 4,
   localparam int IDW   = id_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDW-1:0]   ptr,
   output logic [N_REQ-1:0] gnt_onehot,
   output logic [IDW-1:0]   gnt_id,
   output logic             any
);

   // Two passes: first the indices at or above ptr, then the wrapped ones
   // below ptr. The first hit wins, which gives the rotating priority order.
   always_comb begin
      gnt_onehot = '0;
      gnt_id     = '0;
      any        = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!any && req[i] && (i >= int'(ptr))) begin
            any           = 1'b1;
            gnt_onehot[i] = 1'b1;
            gnt_id        = IDW'(i);
         end
      end
      for (int i = 0; i < N_REQ; i++) begin
         if (!any && req[i] && (i < int'(ptr))) begin
            any           = 1'b1;
            gnt_onehot[i] = 1'b1;
            gnt_id        = IDW'(i);
         end
      end
   end

endmodule

// File: rtl/cmp_share_arbiter.sv
// cmp_share_arbiter: one W-bit comparator shared by N_REQ requesters.
//
// Optional feature macro: CMP_SHARE_MAG_EN
//   defined   -> rsp_gt / rsp_lt carry the unsigned magnitude result.
//   undefined -> no magnitude compare is built; rsp_gt = rsp_lt = 0.
//
// Handshake semantics (both sides): a transfer happens on a rising clk
// edge where valid and ready are both 1. Requesters may drop req_valid at
// any time before seeing req_ready; the grant is re-picked every IDLE
// cycle. Once rsp_valid rises it stays 1, with rsp_id and the flags
// stable, until the cycle rsp_ready is 1.
//
// Flow: IDLE (pick + latch operands) -> CMP (register result) -> RESP
// (hold until consumed). Accept in cycle T gives rsp_valid in cycle T+2.
// dbg_state exposes the FSM for observation.
module cmp_share_arbiter
   import cmp_share_pkg::*;
#(
   parameter  int N_REQ = 4,
   parameter  int W     = 8,
   localparam int IDW   = id_width(N_REQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [N_REQ*W-1:0] req_a,
   input  logic [N_REQ*W-1:0] req_b,
   output logic [N_REQ-1:0]   req_ready,
   output logic               rsp_valid,
   output logic [IDW-1:0]     rsp_id,
   output logic               rsp_eq,
   output logic               rsp_gt,
   output logic               rsp_lt,
   input  logic               rsp_ready,
   output state_t             dbg_state
);

   state_t             state;
   state_t             state_nxt;
   logic [IDW-1:0]     ptr;
   logic [W-1:0]       op_a;
   logic [W-1:0]       op_b;
   logic [W-1:0]       sel_a;
   logic [W-1:0]       sel_b;
   logic [N_REQ-1:0]   gnt_onehot;
   logic [IDW-1:0]     gnt_id;
   logic               gnt_any;
   logic               accept;
   logic               rsp_fire;
   logic [IDW-1:0]     ptr_after;

   assign dbg_state = state;

   rr_pick #(
      .N_REQ (N_REQ)
   ) u_pick (
      .req        (req_valid),
      .ptr        (ptr),
      .gnt_onehot (gnt_onehot),
      .gnt_id     (gnt_id),
      .any        (gnt_any)
   );

   // Operand mux driven by the one-hot grant, so no wide index decode.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt_onehot[i]) begin
            sel_a = sel_a | req_a[i*W +: W];
            sel_b = sel_b | req_b[i*W +: W];
         end
      end
   end

   // Rotation point after serving rsp_id: the next requester, wrapping.
   // With one requester this is constantly 0.
   always_comb begin
      ptr_after = '0;
      if (rsp_id != IDW'(N_REQ - 1)) begin
         ptr_after = rsp_id + IDW'(1);
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state plus the combinational acceptance strobe.
   always_comb begin
      state_nxt = state;
      req_ready = '0;
      accept    = 1'b0;
      rsp_fire  = 1'b0;
      case (state)
         IDLE: begin
            req_ready = gnt_onehot;
            if (gnt_any) begin
               accept    = 1'b1;
               state_nxt = CMP;
            end
         end
         CMP: begin
            state_nxt = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_fire  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Round-robin pointer advances only when a result is consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (rsp_fire) begin
         ptr <= ptr_after;
      end
   end

   // Capture the winning operands and ID on the acceptance edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a   <= '0;
         op_b   <= '0;
         rsp_id <= '0;
      end else if (accept) begin
         op_a   <= sel_a;
         op_b   <= sel_b;
         rsp_id <= gnt_id;
      end
   end

   // Result valid: rises after the compare cycle, falls on consumption.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
      end else if (state == CMP) begin
         rsp_valid <= 1'b1;
      end else if (rsp_fire) begin
         rsp_valid <= 1'b0;
      end
   end

   // Equality flag, rewritten on every compare.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_eq <= 1'b0;
      end else if (state == CMP) begin
         rsp_eq <= (op_a == op_b);
      end
   end

`ifdef CMP_SHARE_MAG_EN
   // Unsigned magnitude flags, rewritten on every compare.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_gt <= 1'b0;
         rsp_lt <= 1'b0;
      end else if (state == CMP) begin
         rsp_gt <= (op_a > op_b);
         rsp_lt <= (op_a < op_b);
      end
   end
`else
   // Magnitude compare not built: the flags stay at 0.
   assign rsp_gt = 1'b0;
   assign rsp_lt = 1'b0;
`endif

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Directed bench for cmp_share_arbiter (N_REQ=4, W=8).
// A transaction-level model (busy flag, accept cycle, rotation pointer and
// an expected-result queue) predicts req_ready, rsp_valid and the response
// fields every cycle; directed scenarios add hand-computed literal checks.
module tb_cmp_share_arbiter;
   import cmp_share_pkg::*;

   localparam int N_REQ  = 4;
   localparam int W      = 8;
   localparam int IDW    = 2;
   localparam int RW     = IDW + 3;
   localparam int BUDGET = 40;
`ifdef CMP_SHARE_MAG_EN
   localparam bit MAG_EN = 1'b1;
`else
   localparam bit MAG_EN = 1'b0;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic               clk       = 1'b0;
   logic               rst_n     = 1'b0;
   logic [N_REQ-1:0]   req_valid = '0;
   logic [N_REQ*W-1:0] req_a     = '0;
   logic [N_REQ*W-1:0] req_b     = '0;
   logic               rsp_ready = 1'b0;
   logic [N_REQ-1:0]   req_ready;
   logic               rsp_valid;
   logic [IDW-1:0]     rsp_id;
   logic               rsp_eq;
   logic               rsp_gt;
   logic               rsp_lt;
   state_t             dbg_state;

   always #5 clk = ~clk;

   cmp_share_arbiter #(
      .N_REQ (N_REQ),
      .W     (W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_eq    (rsp_eq),
      .rsp_gt    (rsp_gt),
      .rsp_lt    (rsp_lt),
      .rsp_ready (rsp_ready),
      .dbg_state (dbg_state)
   );

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- model ----------------
   bit              m_busy = 1'b0;
   int              m_acc  = 0;
   int              m_ptr  = 0;
   int              m_id   = 0;
   logic [RW-1:0]   exp_q[$];

   // DUT observation logs used by the directed literal checks.
   int              g_ids[$];
   int              g_cyc[$];
   logic [RW-1:0]   r_log[$];
   int              r_cyc[$];

   function automatic int pick(input logic [N_REQ-1:0] v, input int p);
      for (int k = 0; k < N_REQ; k++) begin
         if (v[(p + k) % N_REQ]) return (p + k) % N_REQ;
      end
      return -1;
   endfunction

   function automatic logic [RW-1:0] expect_rsp(input int id, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
      logic [IDW-1:0] idv;
      idv = id[IDW-1:0];
      return {idv, a == b, MAG_EN && (a > b), MAG_EN && (a < b)};
   endfunction

   // Model advance on each edge: accept when idle, retire when consumed.
   always @(posedge clk) begin : model_upd
      int g;
      if (!rst_n) begin
         m_busy = 1'b0;
         m_ptr  = 0;
         exp_q.delete();
      end else if (!m_busy) begin
         g = pick(req_valid, m_ptr);
         if (g >= 0) begin
            exp_q.push_back(expect_rsp(g, req_a[g*W +: W], req_b[g*W +: W]));
            m_busy = 1'b1;
            m_acc  = cyc;
            m_id   = g;
         end
      end else if ((cyc >= m_acc + 2) && rsp_ready) begin
         m_ptr  = (m_id + 1) % N_REQ;
         void'(exp_q.pop_front());
         m_busy = 1'b0;
      end
   end

   // Per-cycle compare against the model, plus logging of observed traffic.
   always @(negedge clk) begin : compare
      logic [N_REQ-1:0] e_ready;
      bit               e_rv;
      int               g;
      if (rst_n) begin
         e_ready = '0;
         if (!m_busy) begin
            g = pick(req_valid, m_ptr);
            if (g >= 0) e_ready[g] = 1'b1;
         end
         check("req_ready", req_ready, e_ready);
         e_rv = m_busy && (cyc >= m_acc + 2);
         check("rsp_valid", rsp_valid, e_rv);
         if (e_rv && exp_q.size() > 0) begin
            check("rsp_fields", {rsp_id, rsp_eq, rsp_gt, rsp_lt}, exp_q[0]);
         end
         for (int i = 0; i < N_REQ; i++) begin
            if (req_ready[i]) begin
               g_ids.push_back(i);
               g_cyc.push_back(cyc);
            end
         end
         if (rsp_valid && rsp_ready) begin
            r_log.push_back({rsp_id, rsp_eq, rsp_gt, rsp_lt});
            r_cyc.push_back(cyc);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b0;
      @(posedge clk);
      #1;
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_fields", {rsp_id, rsp_eq, rsp_gt, rsp_lt}, 0);
      check("rst_state", dbg_state, IDLE);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
      req_valid[i]    = 1'b1;
   endtask

   task automatic wait_grant(output int id);
      id = -1;
      for (int n = 0; n < BUDGET && id < 0; n++) begin
         @(negedge clk);
         for (int i = 0; i < N_REQ; i++) begin
            if (rst_n && req_ready[i]) id = i;
         end
      end
      if (id < 0) begin
         tests++;
         fails++;
         $display("FAIL grant_timeout: got no grant, required one within %0d cycles", BUDGET);
      end
   endtask

   task automatic drop_after(input int id);
      @(posedge clk);
      #1;
      if (id >= 0) req_valid[id] = 1'b0;
   endtask

   task automatic wait_rsp();
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < BUDGET && !seen; n++) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      if (!seen) begin
         tests++;
         fails++;
         $display("FAIL rsp_timeout: got no rsp_valid, required one within %0d cycles", BUDGET);
      end
   endtask

   task automatic drain(input int n_total);
      for (int n = 0; n < BUDGET && r_log.size() < n_total; n++) @(negedge clk);
      if (r_log.size() < n_total) begin
         tests++;
         fails++;
         $display("FAIL drain_timeout: got %0d responses, required %0d", r_log.size(), n_total);
      end
   endtask

   // ---------------- directed scenarios ----------------
   initial begin : main
      int id;
      int id2;
      int bg;
      int br;
      int rr_ids[5];
      int rr_exp[5] = '{0, 1, 2, 3, 0};
      logic [W-1:0] rr_b[4] = '{8'h00, 8'h20, 8'h10, 8'h33};
      logic [RW-1:0] held;

      // Single request, equal operands.
      do_reset();
      bg = g_ids.size();
      br = r_log.size();
      rsp_ready = 1'b1;
      set_req(0, 8'h3C, 8'h3C);
      wait_grant(id);
      drop_after(id);
      drain(br + 1);
      check("s1_gnt_id", id, 0);
      check("s1_latency", r_cyc[br] - g_cyc[bg], 2);
      check("s1_rsp", r_log[br], {2'd0, 1'b1, 1'b0, 1'b0});

      // Magnitude: rotation now starts at 1, requester 2 wins.
      br = r_log.size();
      @(posedge clk);
      #1 set_req(2, 8'h05, 8'hF0);
      wait_grant(id);
      drop_after(id);
      drain(br + 1);
      check("s2_gnt_id", id, 2);
      check("s2_rsp_lt", r_log[br], {2'd2, 1'b0, 1'b0, MAG_EN});
      @(posedge clk);
      #1 set_req(3, 8'hF0, 8'h05);
      wait_grant(id);
      drop_after(id);
      drain(br + 2);
      check("s2_rsp_gt", r_log[br + 1], {2'd3, 1'b0, MAG_EN, 1'b0});

      // Round robin with all four requesters holding valid.
      do_reset();
      bg = g_ids.size();
      br = r_log.size();
      rsp_ready = 1'b1;
      for (int i = 0; i < N_REQ; i++) set_req(i, W'(i * 'h11), rr_b[i]);
      for (int k = 0; k < 5; k++) wait_grant(rr_ids[k]);
      @(posedge clk);
      #1 req_valid = '0;
      drain(br + 5);
      for (int k = 0; k < 5; k++) check("s3_order", rr_ids[k], rr_exp[k]);
      for (int k = 1; k < 5; k++) check("s3_spacing", g_cyc[bg + k] - g_cyc[bg + k - 1], 3);

      // Backpressure: result held 5 cycles, then next grant right after.
      do_reset();
      bg = g_ids.size();
      br = r_log.size();
      set_req(0, 8'hA5, 8'h5A);
      set_req(2, 8'h77, 8'h77);
      wait_grant(id);
      drop_after(id);
      wait_rsp();
      held = {rsp_id, rsp_eq, rsp_gt, rsp_lt};
      check("s4_first", held, {2'd0, 1'b0, MAG_EN, 1'b0});
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         check("s4_hold_valid", rsp_valid, 1);
         check("s4_hold_fields", {rsp_id, rsp_eq, rsp_gt, rsp_lt}, held);
         check("s4_no_ready", req_ready, 0);
      end
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      wait_grant(id2);
      drop_after(id2);
      drain(br + 2);
      check("s4_next_id", id2, 2);
      check("s4_next_gap", g_cyc[bg + 1] - r_cyc[br], 1);
      check("s4_rsp2", r_log[br + 1], {2'd2, 1'b1, 1'b0, 1'b0});

      // Withdrawal: requester 1 drops before grant, requester 3 holds.
      do_reset();
      br = r_log.size();
      set_req(0, 8'h01, 8'h01);
      wait_grant(id);
      @(posedge clk);
      #1;
      req_valid = '0;
      set_req(1, 8'h12, 8'h12);
      set_req(3, 8'hC0, 8'hC1);
      wait_rsp();
      @(posedge clk);
      #1 req_valid[1] = 1'b0;
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      wait_grant(id2);
      drop_after(id2);
      drain(br + 2);
      repeat (6) @(posedge clk);
      check("s5_gnt_id", id2, 3);
      check("s5_rsp_count", r_log.size() - br, 2);
      check("s5_rsp3", r_log[br + 1], {2'd3, 1'b0, 1'b0, MAG_EN});

      // Reset while in CMP: pointer returns to 0, pending result discarded.
      do_reset();
      rsp_ready = 1'b1;
      br = r_log.size();
      set_req(2, 8'h33, 8'h44);
      wait_grant(id);
      drop_after(id);
      drain(br + 1);
      @(posedge clk);
      #1 set_req(2, 8'h55, 8'h55);
      wait_grant(id);
      check("s6_pre_gnt", id, 2);
      @(negedge clk);
      check("s6_in_cmp", dbg_state, CMP);
      #1;
      rst_n     = 1'b0;
      req_valid = '0;
      #1;
      check("s6_rst_valid", rsp_valid, 0);
      check("s6_rst_state", dbg_state, IDLE);
      br = r_log.size();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      set_req(1, 8'h09, 8'h08);
      set_req(3, 8'h08, 8'h09);
      wait_grant(id);
      drop_after(id);
      wait_grant(id2);
      drop_after(id2);
      drain(br + 2);
      check("s6_first_gnt", id, 1);
      check("s6_second_gnt", id2, 3);
      check("s6_rsp1", r_log[br], {2'd1, 1'b0, MAG_EN, 1'b0});

      // Reset while a result is presented: rsp_valid drops without a clock.
      rsp_ready = 1'b0;
      @(posedge clk);
      #1 set_req(0, 8'hEE, 8'hEE);
      wait_grant(id);
      drop_after(id);
      wait_rsp();
      #1 rst_n = 1'b0;
      #1 check("s7_rst_resp_async", rsp_valid, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
